stage_sequencer: RTL and testbench

Multicycle control sequencer that drives the one-hot stage strobes `s_fe`, `s_dc`, `s_ex`, `s_me`, `s_wb` consumed by `netpath`. It steps one instruction at a time through fetch, decode, execute, memory and writeback. It stalls on memory wait, skips the memory stage when told to, and halts on request or on a memory-wait timeout. It also keeps cycle and retired-instruction counters for the core.

---
 rtl/stage_sequencer_if.sv | 30 +++
 rtl/stage_sequencer.sv | 106 ++++++++++
 tb/tb_stage_sequencer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/stage_sequencer_if.sv
// Control/status bundle between the stage sequencer and its core.
// The master drives the request inputs; the slave (the sequencer) drives strobes and counters.
interface stage_sequencer_if #(
    parameter int unsigned COUNT_W = 32
);
    logic               start;
    logic               mem_wait;
    logic               skip_me;
    logic               halt_req;
    logic               s_fe;
    logic               s_dc;
    logic               s_ex;
    logic               s_me;
    logic               s_wb;
    logic               busy;
    logic               halted;
    logic               fault;
    logic [COUNT_W-1:0] cycles;
    logic [COUNT_W-1:0] instret;

    modport master (
        output start, mem_wait, skip_me, halt_req,
        input  s_fe, s_dc, s_ex, s_me, s_wb, busy, halted, fault, cycles, instret
    );

    modport slave (
        input  start, mem_wait, skip_me, halt_req,
        output s_fe, s_dc, s_ex, s_me, s_wb, busy, halted, fault, cycles, instret
    );
endinterface

// File: rtl/stage_sequencer.sv
// Multicycle FE/DC/EX/ME/WB sequencer with memory-wait stall timeout and cycle/instret counters.
// All outputs are registered, so no input reaches an output combinationally.
module stage_sequencer #(
    parameter int unsigned COUNT_W    = 32,
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    stage_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        StIdle,
        StFe,
        StDc,
        StEx,
        StMe,
        StWb,
        StHalt
    } state_e;

    state_e             r_state;
    state_e             w_next;
    logic [15:0]        r_timer;
    logic [4:0]         r_strobe;
    logic               r_busy;
    logic               r_halted;
    logic               r_fault;
    logic [COUNT_W-1:0] r_cycles;
    logic [COUNT_W-1:0] r_instret;

    logic w_stall;
    logic w_timeout;
    logic w_restart;
    logic w_active;

    assign w_stall   = ((r_state == StFe) || (r_state == StMe)) && bus.mem_wait;
    assign w_timeout = w_stall && (r_timer == 16'(WAIT_LIMIT));
    assign w_restart = (r_state == StHalt) && bus.start;
    assign w_active  = (r_state == StFe) || (r_state == StDc) || (r_state == StEx) ||
                       (r_state == StMe) || (r_state == StWb);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            StIdle:  w_next = bus.start ? StFe : StIdle;
            StFe:    w_next = w_timeout ? StHalt : (bus.mem_wait ? StFe : StDc);
            StDc:    w_next = StEx;
            StEx:    w_next = bus.skip_me ? StWb : StMe;
            StMe:    w_next = w_timeout ? StHalt : (bus.mem_wait ? StMe : StWb);
            StWb:    w_next = bus.halt_req ? StHalt : StFe;
            StHalt:  w_next = bus.start ? StFe : StHalt;
            default: w_next = StIdle;
        endcase
    end

    // Strobes and flags are registered from the next state so they track r_state exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_timer   <= '0;
            r_strobe  <= '0;
            r_busy    <= 1'b0;
            r_halted  <= 1'b0;
            r_fault   <= 1'b0;
            r_cycles  <= '0;
            r_instret <= '0;
        end else begin
            r_state  <= w_next;
            r_strobe <= {w_next == StFe, w_next == StDc, w_next == StEx,
                         w_next == StMe, w_next == StWb};
            r_busy   <= (w_next == StFe) || (w_next == StDc) || (w_next == StEx) ||
                        (w_next == StMe) || (w_next == StWb);
            r_halted <= (w_next == StHalt);
            r_timer  <= (w_stall && !w_timeout) ? r_timer + 16'd1 : 16'd0;

            if (w_restart) begin
                r_fault <= 1'b0;
            end else if (w_timeout) begin
                r_fault <= 1'b1;
            end

            if (w_restart) begin
                r_cycles <= '0;
            end else if (w_active) begin
                r_cycles <= r_cycles + 1'b1;
            end

            if (w_restart) begin
                r_instret <= '0;
            end else if (r_state == StWb) begin
                r_instret <= r_instret + 1'b1;
            end
        end
    end

    assign bus.s_fe    = r_strobe[4];
    assign bus.s_dc    = r_strobe[3];
    assign bus.s_ex    = r_strobe[2];
    assign bus.s_me    = r_strobe[1];
    assign bus.s_wb    = r_strobe[0];
    assign bus.busy    = r_busy;
    assign bus.halted  = r_halted;
    assign bus.fault   = r_fault;
    assign bus.cycles  = r_cycles;
    assign bus.instret = r_instret;
endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboard bench: the driver expands per-instruction plans into expected per-cycle records,
// and a negedge monitor pops one record per cycle and compares it with the DUT outputs.
module tb_stage_sequencer;
    localparam int unsigned CW   = 4;
    localparam int unsigned LIM  = 4;
    localparam int          MASK = (1 << CW) - 1;

    localparam int ST_IDLE = 0;
    localparam int ST_FE   = 1;
    localparam int ST_DC   = 2;
    localparam int ST_EX   = 3;
    localparam int ST_ME   = 4;
    localparam int ST_WB   = 5;
    localparam int ST_HALT = 6;

    typedef struct {
        int stage;
        bit fault;
        int cycles;
        int instret;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    stage_sequencer_if #(.COUNT_W(CW)) bus ();

    stage_sequencer #(
        .COUNT_W   (CW),
        .WAIT_LIMIT(LIM)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_cycles = 0;
    int   m_instret = 0;
    bit   m_fault  = 1'b0;
    exp_t q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input exp_t e);
        logic [4:0] es;
        es = 5'b0;
        if (e.stage >= ST_FE && e.stage <= ST_WB) es = 5'b10000 >> (e.stage - 1);
        check("strobes", {27'b0, bus.s_fe, bus.s_dc, bus.s_ex, bus.s_me, bus.s_wb}, {27'b0, es});
        check("busy", {31'b0, bus.busy}, (e.stage >= ST_FE && e.stage <= ST_WB) ? 1 : 0);
        check("halted", {31'b0, bus.halted}, (e.stage == ST_HALT) ? 1 : 0);
        check("fault", {31'b0, bus.fault}, {31'b0, e.fault});
        check("cycles", {28'b0, bus.cycles}, e.cycles);
        check("instret", {28'b0, bus.instret}, e.instret);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                check_outputs(e);
            end
        end
    end

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Drive this cycle's inputs and record what the DUT should be showing now.
    task automatic present(input int stage, input bit mw, input bit sk, input bit hr, input bit st);
        exp_t e;
        bus.mem_wait = mw;
        bus.skip_me  = sk;
        bus.halt_req = hr;
        bus.start    = st;
        e.stage   = stage;
        e.fault   = m_fault;
        e.cycles  = m_cycles & MASK;
        e.instret = m_instret & MASK;
        q.push_back(e);
    endtask

    task automatic step(input int stage, input bit mw, input bit sk, input bit hr, input bit st);
        present(stage, mw, sk, hr, st);
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (stage >= ST_FE && stage <= ST_WB) m_cycles++;
            if (stage == ST_WB) m_instret++;
            if (stage == ST_HALT && st) begin
                m_cycles  = 0;
                m_instret = 0;
                m_fault   = 1'b0;
            end
        end
    endtask

    // One instruction: fs stall cycles in FE, ms in ME; stalls beyond LIM end in a fault halt.
    task automatic run_instr(input int fs, input bit sk, input int ms, input bit h,
                             output bit stopped);
        stopped = 1'b0;
        for (int j = 0; j <= fs; j++) begin
            bit mw;
            mw = (j < fs);
            step(ST_FE, mw, rb(), rb(), rb());
            if (mw && j == int'(LIM)) begin
                m_fault = 1'b1;
                stopped = 1'b1;
                return;
            end
        end
        step(ST_DC, rb(), rb(), rb(), rb());
        step(ST_EX, rb(), sk, rb(), rb());
        if (!sk) begin
            for (int j = 0; j <= ms; j++) begin
                bit mw;
                mw = (j < ms);
                step(ST_ME, mw, rb(), rb(), rb());
                if (mw && j == int'(LIM)) begin
                    m_fault = 1'b1;
                    stopped = 1'b1;
                    return;
                end
            end
        end
        step(ST_WB, rb(), rb(), h, rb());
        stopped = h;
    endtask

    task automatic halt_then_start(input int n);
        repeat (n) step(ST_HALT, rb(), rb(), rb(), 1'b0);
        step(ST_HALT, rb(), rb(), rb(), 1'b1);
    endtask

    function automatic int pick_stall();
        return ($urandom_range(0, 7) == 0) ? int'(LIM) + 1 : int'($urandom_range(0, LIM));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit stopped;
        bus.start    = 1'b0;
        bus.mem_wait = 1'b0;
        bus.skip_me  = 1'b0;
        bus.halt_req = 1'b0;

        #3;
        check("rst_strobes", {27'b0, bus.s_fe, bus.s_dc, bus.s_ex, bus.s_me, bus.s_wb}, 0);
        check("rst_busy", {31'b0, bus.busy}, 0);
        check("rst_halted", {31'b0, bus.halted}, 0);
        check("rst_fault", {31'b0, bus.fault}, 0);
        check("rst_cycles", {28'b0, bus.cycles}, 0);
        check("rst_instret", {28'b0, bus.instret}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Plain 5-stage run, halt at the second WB.
        step(ST_IDLE, rb(), rb(), rb(), 1'b0);
        step(ST_IDLE, rb(), rb(), rb(), 1'b0);
        step(ST_IDLE, rb(), rb(), rb(), 1'b1);
        run_instr(0, 1'b0, 0, 1'b0, stopped);
        run_instr(0, 1'b0, 0, 1'b1, stopped);
        halt_then_start(2);

        // Three skip_me instructions.
        run_instr(0, 1'b1, 0, 1'b0, stopped);
        run_instr(0, 1'b1, 0, 1'b0, stopped);
        run_instr(0, 1'b1, 0, 1'b1, stopped);
        halt_then_start(1);

        // Stalls in FE and ME.
        run_instr(3, 1'b0, 2, 1'b1, stopped);
        halt_then_start(1);

        // ME timeout, then FE/ME stalls exactly at the limit, then an FE timeout.
        run_instr(0, 1'b0, 10, 1'b0, stopped);
        halt_then_start(2);
        run_instr(int'(LIM), 1'b0, int'(LIM), 1'b0, stopped);
        run_instr(int'(LIM) + 1, 1'b0, 0, 1'b0, stopped);
        halt_then_start(0);

        // Counter wrap: 17 instructions of 5 cycles each.
        for (int i = 0; i < 17; i++) run_instr(0, 1'b0, 0, 1'b0, stopped);

        // Asynchronous reset between edges while in EX.
        step(ST_FE, 1'b0, rb(), rb(), rb());
        step(ST_DC, rb(), rb(), rb(), rb());
        present(ST_EX, rb(), 1'b0, rb(), rb());
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_strobes", {27'b0, bus.s_fe, bus.s_dc, bus.s_ex, bus.s_me, bus.s_wb}, 0);
        check("arst_busy", {31'b0, bus.busy}, 0);
        check("arst_cycles", {28'b0, bus.cycles}, 0);
        check("arst_instret", {28'b0, bus.instret}, 0);
        m_cycles  = 0;
        m_instret = 0;
        m_fault   = 1'b0;
        @(posedge clk);
        #1;
        repeat (3) step(ST_IDLE, rb(), rb(), rb(), 1'b1);
        rst_n = 1'b1;
        step(ST_IDLE, rb(), rb(), rb(), 1'b1);

        // Randomized instruction mix.
        repeat (60) begin
            int fs;
            int ms;
            bit sk;
            bit h;
            fs = pick_stall();
            ms = pick_stall();
            sk = rb();
            h  = ($urandom_range(0, 5) == 0);
            run_instr(fs, sk, ms, h, stopped);
            if (stopped) halt_then_start(int'($urandom_range(0, 3)));
        end

        @(negedge clk);
        #1;
        check("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
